// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: Wishbone slave bus bundle for counter_ctrl.
//   wbs_cyc_i/stb_i/we_i : cycle, strobe, write enable (master -> slave)
//   wbs_sel_i[3:0]       : byte lane enables
//   wbs_adr_i[31:0]      : byte address (slave decodes [4:2])
//   wbs_dat_i[31:0]      : write data
//   wbs_ack_o            : single-cycle acknowledge (slave -> master)
//   wbs_dat_o[31:0]      : read data, valid with ack, 0 otherwise
interface counter_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: Wishbone-programmed controller for an external up-counter.
// Loads RELOAD into the counter, enables counting until the count equals
// COMPARE, flags a sticky MATCH (optional level irq) and optionally repeats.
// A logic-analyzer port may load the counter directly while the FSM idles.
//   wb_clk_i, wb_rst_n_i : clock, async active-low reset
//   wb                   : Wishbone slave (see counter_ctrl_if)
//   la_load_i/la_value_i : LA load request/value; la_grant_o = accepted now
//   cnt_value_i          : current count from the datapath
//   cnt_en_o/cnt_load_o/cnt_load_val_o : datapath increment/load controls
//   irq_o                : MATCH flag & IRQ_EN
// Register map (wbs_adr_i[4:2]): 0 CTRL, 1 RELOAD, 2 COMPARE, 3 STATUS,
// 4 COUNT (RO); other offsets read 0 and ignore writes.
module counter_ctrl #(
  parameter int BITS = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  counter_ctrl_if.slave   wb,
  input  logic            la_load_i,
  input  logic [BITS-1:0] la_value_i,
  output logic            la_grant_o,
  input  logic [BITS-1:0] cnt_value_i,
  output logic            cnt_en_o,
  output logic            cnt_load_o,
  output logic [BITS-1:0] cnt_load_val_o,
  output logic            irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_MATCH} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_ack;
  logic [31:0]     r_dat;
  logic            r_periodic, r_irq_en, r_match, r_la_grant_q;
  logic [BITS-1:0] r_reload, r_compare;

  logic        w_req, w_wr, w_ctrl_wr, w_start, w_stop, w_w1c;
  logic [2:0]  w_off;
  logic [31:0] w_wmask, w_rdata;
  logic [BITS-1:0] w_reload_nxt, w_compare_nxt;
  logic        w_unused_adr;

  // A new request is only taken while ack is low, so acks never come back to back.
  assign w_req     = wb.wbs_cyc_i & wb.wbs_stb_i & ~r_ack;
  assign w_wr      = w_req & wb.wbs_we_i;
  assign w_off     = wb.wbs_adr_i[4:2];
  assign w_ctrl_wr = w_wr & (w_off == 3'd0) & wb.wbs_sel_i[0];
  assign w_start   = w_ctrl_wr & wb.wbs_dat_i[0];
  assign w_stop    = w_ctrl_wr & wb.wbs_dat_i[3];
  assign w_w1c     = w_wr & (w_off == 3'd3) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
  assign w_unused_adr = ^{wb.wbs_adr_i[31:5], wb.wbs_adr_i[1:0]};

  // Expand byte enables into a bit mask.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_wmask[8*g +: 8] = {8{wb.wbs_sel_i[g]}};
  end

  assign w_reload_nxt  = BITS'((32'(r_reload)  & ~w_wmask) | (wb.wbs_dat_i & w_wmask));
  assign w_compare_nxt = BITS'((32'(r_compare) & ~w_wmask) | (wb.wbs_dat_i & w_wmask));

  always_comb begin
    w_rdata = '0;
    case (w_off)
      3'd0: w_rdata = {29'd0, r_irq_en, r_periodic, 1'b0};
      3'd1: w_rdata = 32'(r_reload);
      3'd2: w_rdata = 32'(r_compare);
      3'd3: w_rdata = {29'd0, r_la_grant_q, r_match, (r_state != S_IDLE)};
      3'd4: w_rdata = 32'(cnt_value_i);
      default: w_rdata = '0;
    endcase
  end

  // Next state and datapath controls. The LA port can only load while idle,
  // so it never collides with the FSM's own LOAD.
  always_comb begin
    w_state_nxt    = r_state;
    cnt_en_o       = 1'b0;
    cnt_load_o     = 1'b0;
    cnt_load_val_o = '0;
    la_grant_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        la_grant_o = la_load_i;
        if (la_load_i) begin
          cnt_load_o     = 1'b1;
          cnt_load_val_o = la_value_i;
        end
        if (w_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cnt_load_o     = 1'b1;
        cnt_load_val_o = r_reload;
        w_state_nxt    = S_RUN;
      end
      S_RUN: begin
        // Combinational so the count halts exactly on COMPARE.
        cnt_en_o = (cnt_value_i != r_compare);
        if (cnt_value_i == r_compare) w_state_nxt = S_MATCH;
      end
      S_MATCH: w_state_nxt = r_periodic ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_stop) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_periodic   <= 1'b0;
      r_irq_en     <= 1'b0;
      r_match      <= 1'b0;
      r_la_grant_q <= 1'b0;
      r_reload     <= '0;
      r_compare    <= '0;
    end else begin
      r_ack        <= w_req;
      r_dat        <= w_req ? w_rdata : '0;
      r_la_grant_q <= la_grant_o;
      // Setting wins over a same-cycle W1C so a match is never lost.
      r_match      <= (r_state == S_MATCH) | (r_match & ~w_w1c);
      if (w_ctrl_wr) begin
        r_periodic <= wb.wbs_dat_i[1];
        r_irq_en   <= wb.wbs_dat_i[2];
      end
      if (w_wr && w_off == 3'd1) r_reload  <= w_reload_nxt;
      if (w_wr && w_off == 3'd2) r_compare <= w_compare_nxt;
    end
  end

  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_dat;
  assign irq_o        = r_match & r_irq_en;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: randomized self-checking bench for counter_ctrl.
// The external counter datapath is modelled here (load > +1 on enable);
// expected values come from the register rules and cycle arithmetic.
module tb_counter_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        la_load;
  logic [15:0] la_value;
  logic        la_grant, cnt_en, cnt_load, irq;
  logic [15:0] cnt_load_val, cnt_value;
  int vectors = 0;
  int miscompares = 0;

  counter_ctrl_if wb();

  counter_ctrl #(.BITS(16)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(wb),
    .la_load_i(la_load), .la_value_i(la_value), .la_grant_o(la_grant),
    .cnt_value_i(cnt_value), .cnt_en_o(cnt_en), .cnt_load_o(cnt_load),
    .cnt_load_val_o(cnt_load_val), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // External counter datapath
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_value <= 16'd0;
    else if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en)   cnt_value <= cnt_value + 16'd1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, output logic [31:0] rdata);
    bit got;
    got = 0; rdata = '0;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = we;
    wb.wbs_sel_i = sel; wb.wbs_adr_i = adr; wb.wbs_dat_i = dat;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wb.wbs_ack_o) begin got = 1; rdata = wb.wbs_dat_o; break; end
    end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    vectors++;
    if (!got) begin miscompares++; $display("FAIL ack_timeout adr=%h got=no-ack exp=ack", adr); end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    wb_xfer(adr, dat, 4'hF, 1'b1, d);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(adr, 32'd0, 4'hF, 1'b0, d);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 0; la_load = 0; la_value = 0;
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wb.wbs_ack_o, wb.wbs_dat_o, cnt_en, cnt_load, cnt_load_val, la_grant, irq} !== '0) begin
      miscompares++; $display("FAIL reset_outputs got=nonzero exp=0");
    end
    rst_n = 1;
    @(negedge clk);
    for (int o = 0; o < 5; o++) begin
      rd(32'(o * 4), d);
      vectors++;
      if (d !== 32'd0) begin miscompares++; $display("FAIL reset_reg%0d got=%h exp=0", o, d); end
    end
    @(negedge clk);
    vectors++;
    if (wb.wbs_dat_o !== 32'd0) begin miscompares++; $display("FAIL dat_idle got=%h exp=0", wb.wbs_dat_o); end
  endtask

  task automatic test_byte_lane;
    logic [31:0] d;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
    wb.wbs_sel_i = 4'h1; wb.wbs_adr_i = 32'h8; wb.wbs_dat_i = 32'hABCD;
    @(negedge clk);
    vectors++;
    if (wb.wbs_ack_o !== 1'b1) begin miscompares++; $display("FAIL ack_pulse_hi got=%b exp=1", wb.wbs_ack_o); end
    @(negedge clk);
    vectors++;
    if (wb.wbs_ack_o !== 1'b0) begin miscompares++; $display("FAIL ack_pulse_lo got=%b exp=0", wb.wbs_ack_o); end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    rd(32'h8, d);
    vectors++;
    if (d !== 32'h0000_00CD) begin miscompares++; $display("FAIL compare_lane got=%h exp=000000cd", d); end
  endtask

  task automatic test_regs_random;
    logic [31:0] exp_reg [8];
    logic [31:0] dat, mask, d;
    logic [3:0]  sel;
    int off;
    for (int i = 0; i < 8; i++) exp_reg[i] = 32'd0;
    exp_reg[2] = 32'hCD;
    for (int it = 0; it < 12; it++) begin
      off = $urandom_range(0, 7);
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      if (off == 0) dat = dat & ~32'h9;   // never START/STOP here
      mask = '0;
      for (int b = 0; b < 4; b++) if (sel[b]) mask[8*b +: 8] = 8'hFF;
      wb_xfer(32'(off * 4), dat, sel, 1'b1, d);
      if (off == 1 || off == 2) exp_reg[off] = ((exp_reg[off] & ~mask) | (dat & mask)) & 32'hFFFF;
      if (off == 0 && sel[0]) exp_reg[0] = dat & 32'h6;
      off = $urandom_range(0, 7);
      rd(32'(off * 4), d);
      vectors++;
      if (d !== exp_reg[off]) begin miscompares++; $display("FAIL reg_rw off=%0d got=%h exp=%h", off, d, exp_reg[off]); end
    end
    wr(32'h0, 32'h0);
  endtask

  task automatic test_oneshot(input logic [15:0] rld, input logic [15:0] cmp);
    logic [31:0] d;
    int n, en_cnt;
    n = int'(16'(cmp - rld));
    en_cnt = 0;
    wr(32'h4, 32'(rld)); wr(32'h8, 32'(cmp)); wr(32'hC, 32'h2);
    wr(32'h0, 32'h5);
    vectors++;
    if (cnt_load !== 1'b1 || cnt_load_val !== rld) begin
      miscompares++; $display("FAIL os_load got=%b/%h exp=1/%h", cnt_load, cnt_load_val, rld);
    end
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (cnt_en) en_cnt++;
      vectors++;
      if (cnt_en !== (i < n) || cnt_value !== 16'(rld + 16'(i))) begin
        miscompares++; $display("FAIL os_run i=%0d got=%b/%h exp=%b/%h", i, cnt_en, cnt_value, (i < n), 16'(rld + 16'(i)));
      end
    end
    vectors++;
    if (en_cnt != n) begin miscompares++; $display("FAIL os_en_cycles got=%0d exp=%0d", en_cnt, n); end
    @(negedge clk);
    vectors++;
    if (cnt_en !== 1'b0 || cnt_load !== 1'b0 || cnt_value !== cmp) begin
      miscompares++; $display("FAIL os_match got=%b/%b/%h exp=0/0/%h", cnt_en, cnt_load, cnt_value, cmp);
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL os_irq got=%b exp=1", irq); end
    rd(32'hC, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL os_status got=%h exp=2", d); end
    rd(32'h10, d);
    vectors++;
    if (d !== 32'(cmp)) begin miscompares++; $display("FAIL os_count got=%h exp=%h", d, cmp); end
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    wr(32'h4, 32'h0); wr(32'h8, 32'h2);
    wr(32'h0, 32'h3);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (cnt_load !== (i % 5 == 0)) begin
        miscompares++; $display("FAIL per_load i=%0d got=%b exp=%b", i, cnt_load, (i % 5 == 0));
      end
    end
    rd(32'hC, d);
    vectors++;
    if (d[0] !== 1'b1) begin miscompares++; $display("FAIL per_busy got=%b exp=1", d[0]); end
    wr(32'h0, 32'h8);
    vectors++;
    if (cnt_en !== 1'b0 || cnt_load !== 1'b0) begin
      miscompares++; $display("FAIL per_stop got=%b/%b exp=0/0", cnt_en, cnt_load);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (cnt_en !== 1'b0 || cnt_load !== 1'b0) begin
      miscompares++; $display("FAIL per_stays_idle got=%b/%b exp=0/0", cnt_en, cnt_load);
    end
    rd(32'hC, d);
    vectors++;
    if (d[0] !== 1'b0) begin miscompares++; $display("FAIL per_busy_off got=%b exp=0", d[0]); end
  endtask

  task automatic test_arbitration;
    logic [31:0] d;
    wr(32'h4, 32'h0); wr(32'h8, 32'h100);
    wr(32'h0, 32'h1);
    repeat (2) @(negedge clk);
    la_load = 1; la_value = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (la_grant !== 1'b0 || cnt_load !== 1'b0) begin
        miscompares++; $display("FAIL arb_run got=%b/%b exp=0/0", la_grant, cnt_load);
      end
    end
    wr(32'h0, 32'h8);
    vectors++;
    if (la_grant !== 1'b1 || cnt_load !== 1'b1 || cnt_load_val !== 16'h1234) begin
      miscompares++; $display("FAIL arb_idle got=%b/%b/%h exp=1/1/1234", la_grant, cnt_load, cnt_load_val);
    end
    @(negedge clk);
    rd(32'hC, d);
    vectors++;
    if ((d & 32'h5) !== 32'h4) begin miscompares++; $display("FAIL arb_status got=%h exp=4 (bits 2,0)", d & 32'h5); end
    la_load = 0;
    @(negedge clk);
    vectors++;
    if (la_grant !== 1'b0 || cnt_load !== 1'b0) begin
      miscompares++; $display("FAIL arb_release got=%b/%b exp=0/0", la_grant, cnt_load);
    end
  endtask

  task automatic test_same_cycle;
    logic [31:0] d;
    logic [15:0] v;
    wr(32'h0, 32'h9);
    vectors++;
    if (cnt_load !== 1'b0) begin miscompares++; $display("FAIL start_stop_load got=%b exp=0", cnt_load); end
    @(negedge clk);
    rd(32'hC, d);
    vectors++;
    if (d[0] !== 1'b0) begin miscompares++; $display("FAIL start_stop_busy got=%b exp=0", d[0]); end
    v = 16'($urandom);
    wr(32'h4, 32'(v)); wr(32'h8, 32'(v)); wr(32'hC, 32'h2);
    wr(32'h0, 32'h1);
    @(posedge clk); #1;
    vectors++;
    if (cnt_en !== 1'b0 || cnt_value !== v) begin
      miscompares++; $display("FAIL eq_run got=%b/%h exp=0/%h", cnt_en, cnt_value, v);
    end
    @(posedge clk); #1;
    wb_xfer(32'hC, 32'h2, 4'hF, 1'b1, d);
    rd(32'hC, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL w1c_race got=%h exp=2", d); end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_masked got=%b exp=0", irq); end
    wr(32'hC, 32'h2);
    rd(32'hC, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL w1c_clear got=%h exp=0", d); end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d;
    wr(32'h4, 32'h0); wr(32'h8, 32'h1);
    wr(32'h0, 32'h5);
    repeat (6) @(negedge clk);
    wr(32'h8, 32'h200);
    wr(32'h0, 32'h5);
    repeat (4) @(negedge clk);
    vectors++;
    if (cnt_en !== 1'b1 || irq !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre got=%b/%b exp=1/1", cnt_en, irq);
    end
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 0; wb.wbs_adr_i = 32'h10;
    #2 rst_n = 0;
    #1;
    vectors++;
    if (cnt_en !== 1'b0 || irq !== 1'b0 || cnt_load !== 1'b0 || la_grant !== 1'b0 || wb.wbs_ack_o !== 1'b0) begin
      miscompares++; $display("FAIL rst_async got=%b/%b/%b/%b/%b exp=0", cnt_en, irq, cnt_load, la_grant, wb.wbs_ack_o);
    end
    @(negedge clk);
    vectors++;
    if (wb.wbs_ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack_drop got=%b exp=0", wb.wbs_ack_o); end
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (cnt_en !== 1'b0 || cnt_load !== 1'b0) begin
        miscompares++; $display("FAIL rst_quiet got=%b/%b exp=0/0", cnt_en, cnt_load);
      end
    end
    for (int o = 0; o < 5; o++) begin
      rd(32'(o * 4), d);
      vectors++;
      if (d !== 32'd0) begin miscompares++; $display("FAIL rst_reg%0d got=%h exp=0", o, d); end
    end
  endtask

  initial begin
    logic [15:0] r;
    test_reset();
    test_byte_lane();
    test_regs_random();
    test_oneshot(16'd5, 16'd9);
    test_oneshot(16'hFFFD, 16'h0002);
    for (int it = 0; it < 4; it++) begin
      r = 16'($urandom);
      test_oneshot(r, 16'(r + 16'($urandom_range(0, 12))));
    end
    test_periodic();
    test_arbitration();
    test_same_cycle();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
